cla64_pipe_stage: RTL and testbench

//   Registered handshake stage around cla_64bit: accepts operand triples (a, b, cin) on a

---
 rtl/cla64_pipe_stage.sv | 191 +++++++++++++++++++
 tb/tb_cla64_pipe_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla64_pipe_stage.sv
// cla64_pipe_stage: valid/ready operand register feeding a 64-bit carry-lookahead adder,
// with results queued in a small output FIFO. Define CLA_ADD_SUB_EN to add the in_sub port.

module cla_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    function automatic logic grp_g(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Carries into each position of a 4-wide group, expanded from the group carry-in
    function automatic logic [3:0] grp_c(input logic [3:0] g, input logic [3:0] p, input logic c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    logic [63:0] g, p, c;
    logic [15:0] g1, p1, c1;
    logic [3:0]  g2, p2, c2;

    assign g = a & b;
    assign p = a ^ b;

    // Three-level lookahead tree: bit -> 4-bit group -> 16-bit section
    for (genvar j = 0; j < 16; j++) begin : g_lvl1
        assign g1[j] = grp_g(g[4*j +: 4], p[4*j +: 4]);
        assign p1[j] = &p[4*j +: 4];
    end

    for (genvar k = 0; k < 4; k++) begin : g_lvl2
        assign g2[k] = grp_g(g1[4*k +: 4], p1[4*k +: 4]);
        assign p2[k] = &p1[4*k +: 4];
    end

    assign c2   = grp_c(g2, p2, cin);
    assign cout = grp_g(g2, p2) | (&p2 & cin);

    for (genvar k = 0; k < 4; k++) begin : g_c1
        assign c1[4*k +: 4] = grp_c(g1[4*k +: 4], p1[4*k +: 4], c2[k]);
    end

    for (genvar j = 0; j < 16; j++) begin : g_c0
        assign c[4*j +: 4] = grp_c(g[4*j +: 4], p[4*j +: 4], c1[j]);
    end

    assign sum = p ^ c;

endmodule

module cla64_pipe_stage #(
    parameter int OUT_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [63:0]                  in_a,
    input  logic [63:0]                  in_b,
    input  logic                         in_cin,
`ifdef CLA_ADD_SUB_EN
    input  logic                         in_sub,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [63:0]                  out_sum,
    output logic                         out_cout,
    output logic                         out_ovf,
    output logic [$clog2(OUT_DEPTH):0]   out_count
);

    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(OUT_DEPTH);

    function automatic logic ovf_of(input logic signed [63:0] a,
                                    input logic signed [63:0] b_eff,
                                    input logic signed [63:0] sum);
        return (a[63] == b_eff[63]) && (sum[63] != a[63]);
    endfunction

    logic                vld_p1;
    logic signed [63:0]  a_p1;
    logic signed [63:0]  b_p1;
    logic                cin_p1;
    logic                sub_p1;
    logic signed [63:0]  beff_p1;
    logic                cineff_p1;
    logic signed [63:0]  sum_p1;
    logic                cout_p1;
    logic                ovf_p1;

    logic [63:0]         fifo_sum  [OUT_DEPTH];
    logic                fifo_cout [OUT_DEPTH];
    logic                fifo_ovf  [OUT_DEPTH];
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       rptr;
    logic [CW-1:0]       cnt;

    logic                accept;
    logic                pop;
    logic                push;
    logic                full;

    assign full      = (cnt == FULL_CNT);
    assign out_valid = (cnt != '0);
    assign pop       = out_valid & out_ready;
    assign push      = vld_p1 & (~full | pop);
    assign in_ready  = ~vld_p1 | push;
    assign accept    = in_valid & in_ready;
    assign out_count = cnt;

    // ---- p0 -> p1: operand capture ----
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1   <= in_a;
            b_p1   <= in_b;
            cin_p1 <= in_cin;
        end
    end

`ifdef CLA_ADD_SUB_EN
    always_ff @(posedge clk) begin
        if (accept) begin
            sub_p1 <= in_sub;
        end
    end
`else
    assign sub_p1 = 1'b0;
`endif

    // Subtract is a + ~b + 1; the caller's carry-in is overridden
    assign beff_p1   = sub_p1 ? ~b_p1 : b_p1;
    assign cineff_p1 = sub_p1 | cin_p1;

    cla_64bit u_cla (
        .a    (a_p1),
        .b    (beff_p1),
        .cin  (cineff_p1),
        .sum  (sum_p1),
        .cout (cout_p1)
    );

    assign ovf_p1 = ovf_of(a_p1, beff_p1, sum_p1);

    // ---- p1 -> p2: result FIFO write ----
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_sum[wptr]  <= sum_p1;
            fifo_cout[wptr] <= cout_p1;
            fifo_ovf[wptr]  <= ovf_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            wptr   <= '0;
            rptr   <= '0;
            cnt    <= '0;
        end else begin
            vld_p1 <= accept | (vld_p1 & ~push);
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is never reset, so an empty FIFO must mask whatever the head slot holds
    assign out_sum  = out_valid ? fifo_sum[rptr]  : 64'd0;
    assign out_cout = out_valid ? fifo_cout[rptr] : 1'b0;
    assign out_ovf  = out_valid ? fifo_ovf[rptr]  : 1'b0;

`ifndef SYNTHESIS
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt <= FULL_CNT);
    a_s1_hold:   assert property (@(posedge clk) disable iff (!rst_n) (vld_p1 && !push) |=> vld_p1);
`endif

endmodule

// File: tb/tb_cla64_pipe_stage.sv
// Scoreboard bench for cla64_pipe_stage: accepted operands queue a reference result,
// a monitor pops and compares on every output handshake.

module tb_cla64_pipe_stage;

    localparam int DEPTH = 2;
`ifdef CLA_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_n;
    logic                      in_valid, in_ready, in_cin, in_sub;
    logic [63:0]               in_a, in_b;
    logic                      out_valid, out_ready, out_cout, out_ovf;
    logic [63:0]               out_sum;
    logic [$clog2(DEPTH):0]    out_count;
    logic                      sub_used;

    assign sub_used = in_sub & SUB_EN;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    res_t q[$];
    res_t mon_e;

    cla64_pipe_stage #(.OUT_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef CLA_ADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    // Reference: exact unsigned sum for sum/cout, exact signed sum for overflow
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        res_t r;
        logic [64:0] u;
        logic signed [65:0] s;
        if (sub) begin
            r.sum  = a - b;
            r.cout = (a >= b);
            s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        end else begin
            u = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            r.sum  = u[63:0];
            r.cout = u[64];
            s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'd0, cin});
        end
        r.ovf = !(s[65:63] == 3'b000 || s[65:63] == 3'b111);
        return r;
    endfunction

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'd1;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic rnd_operands();
        in_a   = rnd64();
        in_b   = rnd64();
        in_cin = 1'($urandom_range(0, 1));
        in_sub = 1'($urandom_range(0, 1));
    endtask

    // Monitor first, then issue-side capture, so a pop never sees a same-edge push
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: got sum=%h with nothing pending", out_sum);
                    end else begin
                        mon_e = q.pop_front();
                        chk("result", {out_sum, out_cout, out_ovf}, {mon_e.sum, mon_e.cout, mon_e.ovf});
                    end
                end
            end else begin
                chk("idle_zero", {out_sum, out_cout, out_ovf}, 66'd0);
            end
            if (in_valid && in_ready)
                q.push_back(model(in_a, in_b, in_cin, sub_used));
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("send_accepted", 66'(ok), 66'd1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && !(q.size() == 0 && !out_valid); k++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 66'(q.size() == 0 && !out_valid), 66'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  acc;
        int  i;
        bit  took;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 66'(out_valid), 66'd0);
        chk("rst_out_count", 66'(out_count), 66'd0);
        chk("rst_in_ready",  66'(in_ready),  66'd1);
        chk("rst_out_sum",   66'(out_sum),   66'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: accepted at edge N, visible after edge N+1
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 64'd1; in_b = 64'd2; in_cin = 1'b1; in_sub = 1'b0;
        @(negedge clk);
        chk("lat_in_ready", 66'(in_ready), 66'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat_not_yet", 66'(out_valid), 66'd0);
        @(posedge clk); #1;
        chk("lat_valid", 66'(out_valid), 66'd1);
        chk("lat_sum", {out_sum, out_cout, out_ovf}, {64'd4, 1'b0, 1'b0});
        drain();

        // Carry-out and signed overflow corners
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
        if (SUB_EN) begin
            send(64'd5, 64'd7, 1'b0, 1'b1);
            send(64'd7, 64'd5, 1'b1, 1'b1);
            send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        end
        drain();

        // Backpressure: one in S1 plus a full FIFO, then in order release
        out_ready = 1'b0;
        acc = 0;
        i = 1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            in_valid = 1'b1; in_a = 64'(i); in_b = 64'd0; in_cin = 1'b0; in_sub = 1'b0;
            @(negedge clk);
            took = in_ready;
            @(posedge clk); #1;
            if (took) begin acc++; i++; end
        end
        @(negedge clk);
        chk("bp_accepted", 66'(acc), 66'(DEPTH + 1));
        chk("bp_in_ready", 66'(in_ready), 66'd0);
        chk("bp_count", 66'(out_count), 66'(DEPTH));
        @(posedge clk); #1;
        out_ready = 1'b1;
        while (i <= 6) begin
            send(64'(i), 64'd0, 1'b0, 1'b0);
            i++;
        end
        drain();

        // Full FIFO with continuous traffic on both sides
        out_ready = 1'b0;
        in_valid = 1'b1;
        rnd_operands();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!in_ready) break;
            @(posedge clk); #1;
            rnd_operands();
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("stream_in_ready", 66'(in_ready), 66'd1);
            chk("stream_count", 66'(out_count), 66'(DEPTH));
            chk("stream_valid", 66'(out_valid), 66'd1);
            @(posedge clk); #1;
            rnd_operands();
        end
        drain();

        // Random traffic; operands held while stalled
        in_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            if (took || !in_valid) begin
                rnd_operands();
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        // Reset with S1 and FIFO occupied
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            rnd_operands();
            @(posedge clk); #1;
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        q.delete();
        #1;
        chk("midrst_out_valid", 66'(out_valid), 66'd0);
        chk("midrst_out_count", 66'(out_count), 66'd0);
        chk("midrst_in_ready",  66'(in_ready),  66'd1);
        chk("midrst_out_sum",   66'(out_sum),   66'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_valid", 66'(out_valid), 66'd0);
        chk("post_rst_count", 66'(out_count), 66'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
